pomodoro_session_scheduler: RTL and testbench
=============================================

Name: pomodoro_session_scheduler

Overview:
Sequences a Pomodoro session: alternates WORK and break phases, with a long break after every LONG_EVERY work phases. Counts each phase down in BCD mm:ss, with an internal 1 s prescaler. Outputs feed the BCD-to-7-segment decoders. disp_vld_o drives the 74HC595 display controller vld input. Button inputs are single-cycle pulses from the upstream edge detectors.

Parameters:
TICK_DIV, 125000000, clk cycles per 1 s tick (legal range 2..2^27)
WORK_MIN, 25, work phase length in minutes (legal range 1..99)
SHORT_MIN, 5, short break length in minutes (legal range 1..99)
LONG_MIN, 15, long break length in minutes (legal range 1..99)
LONG_EVERY, 4, number of completed work phases per long break (legal range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start_i  in  1  pulse; starts a session from IDLE
pause_i  in  1  pulse; toggles pause/resume
skip_i  in  1  pulse; ends the current phase immediately
abort_i  in  1  pulse; returns to IDLE
phase_o  out  3  0=IDLE 1=WORK 2=SHORT 3=LONG; while paused, shows the saved phase
run_o  out  1  1 while counting (WORK/SHORT/LONG, not paused)
paused_o  out  1  1 in PAUSE
min_bcd_o  out  8  remaining minutes, two BCD digits
sec_bcd_o  out  8  remaining seconds, two BCD digits (00..59)
session_bcd_o  out  8  completed work phases, two BCD digits, wraps 99->00
phase_done_o  out  1  one-cycle pulse on each phase end (natural or skip)
disp_vld_o  out  1  one-cycle pulse after any displayed output changes

Behaviour:
- Reset values, all asynchronous: state IDLE, phase_o 0, run_o 0, paused_o 0, min_bcd_o = WORK_MIN in BCD, sec_bcd_o 00, session_bcd_o 00, cycle position 0, prescaler 0, phase_done_o 0. disp_vld_o is 1 in the first cycle after rst deasserts, then 0.
- States: IDLE, WORK, SHORT, LONG, PAUSE. PAUSE holds the saved phase.
- Prescaler:
  - Counts only when run_o=1.
  - tick asserts when the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - The prescaler holds its value in PAUSE.
  - The prescaler clears on start, on any phase load, and on abort.
- Countdown on tick:
  - ss>00: ss-1.
  - ss=00: ss=59 and mm-1.
  - All arithmetic is done directly in BCD; no dividers.
- Phase end: a tick while the value is 00:01. 00:00 is never displayed. Each phase lasts exactly MIN*60 ticks.
- Transitions:
  - IDLE + start_i -> WORK; load WORK_MIN:00. start_i is ignored in every other state.
  - WORK end: session_bcd_o+1; cycle position +1. If cycle position reaches LONG_EVERY -> LONG, load LONG_MIN, cycle position 0. Otherwise -> SHORT, load SHORT_MIN.
  - SHORT or LONG end -> WORK; load WORK_MIN.
  - The new phase value is visible in the cycle after the ending tick. phase_done_o pulses in that same cycle.
  - pause_i in WORK/SHORT/LONG -> PAUSE; the phase is saved and mm:ss is held.
  - pause_i in PAUSE -> saved phase; counting resumes from the held prescaler value.
  - pause_i in IDLE is ignored.
  - skip_i in WORK -> SHORT; load SHORT_MIN; session count and cycle position are unchanged.
  - skip_i in SHORT or LONG -> WORK.
  - skip_i in PAUSE applies to the saved phase and leaves the block running (not paused).
  - abort_i from any state -> IDLE; reload WORK_MIN:00; cycle position 0. session_bcd_o is preserved.
- Simultaneous events:
  - Priority: abort > skip > pause > start > tick.
  - skip_i coinciding with an end-of-phase tick gives one transition, one phase_done_o, and no session increment.
  - pause_i coinciding with a tick: the tick is discarded and the block enters PAUSE.
- disp_vld_o: registered. Pulses the cycle after any change of phase_o, min_bcd_o, sec_bcd_o or session_bcd_o. At most one pulse per change cycle.
- rst mid-operation immediately restores all reset values. No pending event survives reset.

Decomposition:
- Package pomodoro_pkg holds:
  - phase encodings PH_IDLE/PH_WORK/PH_SHORT/PH_LONG;
  - a function converting 0..99 to 2-digit BCD, for parameter loads.
- Sub-module bcd_mmss_down_counter:
  - inputs: load, load_min, dec;
  - outputs: mm, ss, is_0001 flag.
- The scheduler FSM, prescaler, session counter and disp_vld_o logic stay in the top module.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, WORK_MIN=2, SHORT_MIN=1, LONG_MIN=3, LONG_EVERY=2.
1. Reset release -> phase 0, 02:00, session 00, run_o 0, one disp_vld_o pulse. start_i -> WORK; 4 cycles later 01:59; 60 ticks after start, 01:00 -> 00:59 borrow is correct.
2. Run WORK to the end (120 ticks = 480 cycles) -> phase_done_o pulse, SHORT, 01:00, session 01. After 60 more ticks -> WORK 02:00.
3. Complete the second WORK -> LONG, 03:00, session 02. Complete LONG -> WORK, cycle position 0.
4. pause_i at WORK 01:30 with prescaler=2, hold 100 cycles -> outputs frozen, run_o 0, paused_o 1. pause_i again -> next tick after 2 cycles gives 01:29.
5. skip_i in WORK -> SHORT, session unchanged. skip_i in the same cycle as the 00:01 tick -> exactly one phase_done_o, no increment. Check the priority cases: abort+skip -> IDLE; pause+tick -> PAUSE with the tick discarded.
6. abort_i in LONG -> IDLE, 02:00, session kept. Assert rst mid-WORK between clock edges -> immediate reset values. Drive session 99 -> next WORK completion shows session 00.

Source files
------------

// File: rtl/pomodoro_pkg.sv
// Shared phase/state encodings and two-digit BCD helpers for the Pomodoro scheduler.
package pomodoro_pkg;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_WORK  = 3'd1;
    localparam logic [2:0] PH_SHORT = 3'd2;
    localparam logic [2:0] PH_LONG  = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WORK  = 3'd1,
        ST_SHORT = 3'd2,
        ST_LONG  = 3'd3,
        ST_PAUSE = 3'd4
    } state_e;

    // Only used on elaboration-time constants, so the divide never reaches hardware.
    function automatic logic [7:0] to_bcd2(input int unsigned value);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'((value / 10) % 10);
        ones = 4'(value % 10);
        return {tens, ones};
    endfunction

    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd9) begin
                return 8'h00;
            end
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd2_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mmss_down_counter.sv
// mm:ss countdown held as four BCD digits; load wins over decrement.
module bcd_mmss_down_counter
    import pomodoro_pkg::*;
#(
    parameter logic [7:0] RESET_MIN = 8'h25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_min_i,
    input  logic       dec_i,
    output logic [7:0] mm_o,
    output logic [7:0] ss_o,
    output logic       is_0001_o
);

    logic [7:0] mm_q, mm_d;
    logic [7:0] ss_q, ss_d;

    always_comb begin
        mm_d = mm_q;
        ss_d = ss_q;
        if (load_i) begin
            mm_d = load_min_i;
            ss_d = 8'h00;
        end else if (dec_i) begin
            if (ss_q == 8'h00) begin
                ss_d = 8'h59;
                mm_d = bcd2_dec(mm_q);
            end else begin
                ss_d = bcd2_dec(ss_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_q <= RESET_MIN;
            ss_q <= 8'h00;
        end else begin
            mm_q <= mm_d;
            ss_q <= ss_d;
        end
    end

    assign mm_o      = mm_q;
    assign ss_o      = ss_q;
    assign is_0001_o = (mm_q == 8'h00) && (ss_q == 8'h01);

endmodule

// File: rtl/pomodoro_session_scheduler.sv
// Pomodoro session FSM: WORK/SHORT/LONG sequencing, 1 s prescaler, BCD session
// counter and a display-valid strobe for the downstream shift-register loader.
module pomodoro_session_scheduler
    import pomodoro_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 125000000,
    parameter int unsigned WORK_MIN   = 25,
    parameter int unsigned SHORT_MIN  = 5,
    parameter int unsigned LONG_MIN   = 15,
    parameter int unsigned LONG_EVERY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       skip_i,
    input  logic       abort_i,
    output logic [2:0] phase_o,
    output logic       run_o,
    output logic       paused_o,
    output logic [7:0] min_bcd_o,
    output logic [7:0] sec_bcd_o,
    output logic [7:0] session_bcd_o,
    output logic       phase_done_o,
    output logic       disp_vld_o
);

    localparam int unsigned    PW           = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  TICK_LAST    = PW'(TICK_DIV - 1);
    localparam logic [7:0]     WORK_BCD     = to_bcd2(WORK_MIN);
    localparam logic [7:0]     SHORT_BCD    = to_bcd2(SHORT_MIN);
    localparam logic [7:0]     LONG_BCD     = to_bcd2(LONG_MIN);
    localparam logic [3:0]     LONG_EVERY_C = 4'(LONG_EVERY);

    state_e        state_q, state_d;
    state_e        saved_q, saved_d;
    state_e        resume_st;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    cyc_q, cyc_d;
    logic [7:0]    session_q, session_d;
    logic          done_q, done_d;
    logic          active, tick;
    logic          load, dec;
    logic [7:0]    load_min;
    logic [7:0]    mm, ss;
    logic          is_0001;

    logic [2:0]    phase_prev_q;
    logic [7:0]    mm_prev_q, ss_prev_q, session_prev_q;
    logic          vld_q;

    bcd_mmss_down_counter #(
        .RESET_MIN (WORK_BCD)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .load_min_i (load_min),
        .dec_i      (dec),
        .mm_o       (mm),
        .ss_o       (ss),
        .is_0001_o  (is_0001)
    );

    assign active    = (state_q == ST_WORK) || (state_q == ST_SHORT) || (state_q == ST_LONG);
    assign tick      = active && (presc_q == TICK_LAST);
    assign resume_st = (state_q == ST_PAUSE) ? saved_q : state_q;

    // Events are resolved strictly abort > skip > pause > start > tick.
    always_comb begin
        state_d   = state_q;
        saved_d   = saved_q;
        presc_d   = presc_q;
        cyc_d     = cyc_q;
        session_d = session_q;
        done_d    = 1'b0;
        load      = 1'b0;
        load_min  = WORK_BCD;
        dec       = 1'b0;
        if (active) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (abort_i) begin
            state_d = ST_IDLE;
            load    = 1'b1;
            cyc_d   = 4'd0;
            presc_d = '0;
        end else if (skip_i && (state_q != ST_IDLE)) begin
            done_d  = 1'b1;
            load    = 1'b1;
            presc_d = '0;
            if (resume_st == ST_WORK) begin
                state_d  = ST_SHORT;
                load_min = SHORT_BCD;
            end else begin
                state_d  = ST_WORK;
            end
        end else if (pause_i && (state_q != ST_IDLE)) begin
            presc_d = presc_q;
            if (state_q == ST_PAUSE) begin
                state_d = saved_q;
            end else begin
                state_d = ST_PAUSE;
                saved_d = state_q;
            end
        end else if (start_i && (state_q == ST_IDLE)) begin
            state_d = ST_WORK;
            load    = 1'b1;
            presc_d = '0;
        end else if (tick) begin
            if (is_0001) begin
                done_d = 1'b1;
                load   = 1'b1;
                if (state_q == ST_WORK) begin
                    session_d = bcd2_inc(session_q);
                    if (cyc_q + 4'd1 == LONG_EVERY_C) begin
                        state_d  = ST_LONG;
                        load_min = LONG_BCD;
                        cyc_d    = 4'd0;
                    end else begin
                        state_d  = ST_SHORT;
                        load_min = SHORT_BCD;
                        cyc_d    = cyc_q + 4'd1;
                    end
                end else begin
                    state_d = ST_WORK;
                end
            end else begin
                dec = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            saved_q   <= ST_WORK;
            presc_q   <= '0;
            cyc_q     <= 4'd0;
            session_q <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            presc_q   <= presc_d;
            cyc_q     <= cyc_d;
            session_q <= session_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        case (resume_st)
            ST_WORK:  phase_o = PH_WORK;
            ST_SHORT: phase_o = PH_SHORT;
            ST_LONG:  phase_o = PH_LONG;
            default:  phase_o = PH_IDLE;
        endcase
    end

    // Delayed copy of the displayed values; any difference raises one strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_prev_q   <= PH_IDLE;
            mm_prev_q      <= WORK_BCD;
            ss_prev_q      <= 8'h00;
            session_prev_q <= 8'h00;
            vld_q          <= 1'b1;
        end else begin
            phase_prev_q   <= phase_o;
            mm_prev_q      <= mm;
            ss_prev_q      <= ss;
            session_prev_q <= session_q;
            vld_q          <= (phase_o != phase_prev_q) || (mm != mm_prev_q) ||
                              (ss != ss_prev_q) || (session_q != session_prev_q);
        end
    end

    assign run_o         = active;
    assign paused_o      = (state_q == ST_PAUSE);
    assign min_bcd_o     = mm;
    assign sec_bcd_o     = ss;
    assign session_bcd_o = session_q;
    assign phase_done_o  = done_q;
    assign disp_vld_o    = vld_q;

endmodule

// File: tb/tb_pomodoro_session_scheduler.sv
// Self-checking bench: directed scenarios plus random pulses against a seconds-based model.
module tb_pomodoro_session_scheduler;

    localparam int TICK_DIV   = 4;
    localparam int WORK_MIN   = 2;
    localparam int SHORT_MIN  = 1;
    localparam int LONG_MIN   = 3;
    localparam int LONG_EVERY = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       startI = 1'b0, pauseI = 1'b0, skipI = 1'b0, abortI = 1'b0;
    logic [2:0] phase_o;
    logic       run_o, paused_o, phase_done_o, disp_vld_o;
    logic [7:0] min_bcd_o, sec_bcd_o, session_bcd_o;

    int compareCount  = 0;
    int mismatchCount = 0;
    int cycleCount    = 0;

    // Reference model: remaining time kept as whole seconds.
    int          mPhase, mRem, mPresc, mCyc, mSess;
    bit          mPaused, mDone, mVld;
    logic [31:0] curDisp, lastDisp;

    pomodoro_session_scheduler #(
        .TICK_DIV   (TICK_DIV),
        .WORK_MIN   (WORK_MIN),
        .SHORT_MIN  (SHORT_MIN),
        .LONG_MIN   (LONG_MIN),
        .LONG_EVERY (LONG_EVERY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (startI),
        .pause_i       (pauseI),
        .skip_i        (skipI),
        .abort_i       (abortI),
        .phase_o       (phase_o),
        .run_o         (run_o),
        .paused_o      (paused_o),
        .min_bcd_o     (min_bcd_o),
        .sec_bcd_o     (sec_bcd_o),
        .session_bcd_o (session_bcd_o),
        .phase_done_o  (phase_done_o),
        .disp_vld_o    (disp_vld_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] toBcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function logic [31:0] dispWord();
        return {toBcd(mPhase), toBcd(mRem / 60), toBcd(mRem % 60), toBcd(mSess)};
    endfunction

    function int phaseMinutes(input int p);
        if (p == 2) return SHORT_MIN;
        if (p == 3) return LONG_MIN;
        return WORK_MIN;
    endfunction

    task checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compareCount++;
        if (obs !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cycleCount, obs, exp);
        end
    endtask

    task modelReset();
        mPhase  = 0;
        mPaused = 0;
        mRem    = WORK_MIN * 60;
        mPresc  = 0;
        mCyc    = 0;
        mSess   = 0;
        mDone   = 0;
        mVld    = 1;
        curDisp  = dispWord();
        lastDisp = curDisp;
    endtask

    task enterPhase(input int p);
        mPhase  = p;
        mPaused = 0;
        mPresc  = 0;
        mRem    = phaseMinutes(p) * 60;
    endtask

    task modelStep();
        bit running;
        bit tick;
        if (rst) begin
            modelReset();
            return;
        end
        mVld     = (curDisp != lastDisp);
        lastDisp = curDisp;
        mDone    = 0;
        running  = (mPhase != 0) && !mPaused;
        tick     = running && (mPresc == TICK_DIV - 1);
        if (abortI) begin
            mPhase  = 0;
            mPaused = 0;
            mRem    = WORK_MIN * 60;
            mCyc    = 0;
            mPresc  = 0;
        end else if (skipI && mPhase != 0) begin
            enterPhase(mPhase == 1 ? 2 : 1);
            mDone = 1;
        end else if (pauseI && mPhase != 0) begin
            mPaused = !mPaused;
        end else if (startI && mPhase == 0) begin
            enterPhase(1);
        end else if (running) begin
            if (!tick) begin
                mPresc++;
            end else if (mRem > 1) begin
                mPresc = 0;
                mRem--;
            end else begin
                mDone = 1;
                if (mPhase == 1) begin
                    mSess = (mSess + 1) % 100;
                    mCyc++;
                    if (mCyc == LONG_EVERY) begin
                        mCyc = 0;
                        enterPhase(3);
                    end else begin
                        enterPhase(2);
                    end
                end else begin
                    enterPhase(1);
                end
            end
        end
        curDisp = dispWord();
    endtask

    task compareAll();
        checkOutput("phase",   phase_o,       toBcd(mPhase));
        checkOutput("run",     run_o,         (mPhase != 0 && !mPaused) ? 8'd1 : 8'd0);
        checkOutput("paused",  paused_o,      mPaused ? 8'd1 : 8'd0);
        checkOutput("min",     min_bcd_o,     toBcd(mRem / 60));
        checkOutput("sec",     sec_bcd_o,     toBcd(mRem % 60));
        checkOutput("session", session_bcd_o, toBcd(mSess));
        checkOutput("done",    phase_done_o,  mDone ? 8'd1 : 8'd0);
        checkOutput("dispVld", disp_vld_o,    mVld ? 8'd1 : 8'd0);
    endtask

    // One clock cycle with the given pulses; outputs checked at the following negedge.
    task applyStimulus(input bit s, input bit p, input bit k, input bit a);
        startI = s;
        pauseI = p;
        skipI  = k;
        abortI = a;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        cycleCount++;
        compareAll();
        startI = 0;
        pauseI = 0;
        skipI  = 0;
        abortI = 0;
    endtask

    task idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
    endtask

    task releaseReset();
        rst = 1'b0;
        #1;
        checkOutput("vldAfterRst", disp_vld_o, 8'd1);
        checkOutput("phaseAfterRst", phase_o, 8'd0);
        checkOutput("minAfterRst", min_bcd_o, 8'h02);
        checkOutput("secAfterRst", sec_bcd_o, 8'h00);
        checkOutput("runAfterRst", run_o, 8'd0);
    endtask

    initial begin
        modelReset();
        idle(3);
        releaseReset();
        checkOutput("sessAfterRst", session_bcd_o, 8'h00);

        // Start and first borrow
        applyStimulus(1, 0, 0, 0);
        checkOutput("startPhase", phase_o, 8'd1);
        idle(4);
        checkOutput("firstTickMin", min_bcd_o, 8'h01);
        checkOutput("firstTickSec", sec_bcd_o, 8'h59);
        idle(236);
        checkOutput("minBoundMin", min_bcd_o, 8'h01);
        checkOutput("minBoundSec", sec_bcd_o, 8'h00);
        idle(4);
        checkOutput("borrowMin", min_bcd_o, 8'h00);
        checkOutput("borrowSec", sec_bcd_o, 8'h59);

        // Natural end of WORK then SHORT
        idle(235);
        checkOutput("lastSec", sec_bcd_o, 8'h01);
        idle(1);
        checkOutput("endDone", phase_done_o, 8'd1);
        checkOutput("shortPhase", phase_o, 8'd2);
        checkOutput("shortMin", min_bcd_o, 8'h01);
        checkOutput("sess1", session_bcd_o, 8'h01);
        idle(240);
        checkOutput("backWork", phase_o, 8'd1);
        checkOutput("backWorkMin", min_bcd_o, 8'h02);

        // Second WORK -> LONG -> WORK -> SHORT
        idle(480);
        checkOutput("longPhase", phase_o, 8'd3);
        checkOutput("longMin", min_bcd_o, 8'h03);
        checkOutput("sess2", session_bcd_o, 8'h02);
        idle(720);
        checkOutput("afterLong", phase_o, 8'd1);
        idle(480);
        checkOutput("cycReset", phase_o, 8'd2);
        checkOutput("sess3", session_bcd_o, 8'h03);

        // Pause at 01:30 with prescaler 2
        applyStimulus(0, 0, 1, 0);
        checkOutput("skipToWork", phase_o, 8'd1);
        idle(122);
        checkOutput("at130", sec_bcd_o, 8'h30);
        applyStimulus(0, 1, 0, 0);
        idle(100);
        checkOutput("heldMin", min_bcd_o, 8'h01);
        checkOutput("heldSec", sec_bcd_o, 8'h30);
        checkOutput("heldPaused", paused_o, 8'd1);
        checkOutput("heldRun", run_o, 8'd0);
        checkOutput("heldPhase", phase_o, 8'd1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("resumeRun", run_o, 8'd1);
        idle(2);
        checkOutput("resumeSec", sec_bcd_o, 8'h29);

        // Skip cases and priority cases
        applyStimulus(0, 0, 1, 0);
        checkOutput("skipShort", phase_o, 8'd2);
        checkOutput("skipSess", session_bcd_o, 8'h03);
        applyStimulus(0, 0, 1, 0);
        idle(479);
        checkOutput("skipEdgeSec", sec_bcd_o, 8'h01);
        applyStimulus(0, 0, 1, 0);
        checkOutput("skipEdgeDone", phase_done_o, 8'd1);
        checkOutput("skipEdgePhase", phase_o, 8'd2);
        checkOutput("skipEdgeSess", session_bcd_o, 8'h03);
        idle(1);
        checkOutput("skipEdgeOnce", phase_done_o, 8'd0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("abortSkip", phase_o, 8'd0);
        checkOutput("abortSkipMin", min_bcd_o, 8'h02);
        applyStimulus(1, 0, 0, 0);
        idle(3);
        applyStimulus(0, 1, 0, 0);
        checkOutput("pauseTickPaused", paused_o, 8'd1);
        checkOutput("pauseTickSec", sec_bcd_o, 8'h00);
        applyStimulus(0, 1, 0, 0);
        idle(1);
        checkOutput("pauseTickResume", sec_bcd_o, 8'h59);

        // Abort in LONG keeps session
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        idle(480);
        applyStimulus(0, 0, 1, 0);
        idle(480);
        checkOutput("long2Phase", phase_o, 8'd3);
        checkOutput("sess5", session_bcd_o, 8'h05);
        idle(20);
        applyStimulus(0, 0, 0, 1);
        checkOutput("abortLongPhase", phase_o, 8'd0);
        checkOutput("abortLongMin", min_bcd_o, 8'h02);
        checkOutput("abortLongSec", sec_bcd_o, 8'h00);
        checkOutput("abortLongSess", session_bcd_o, 8'h05);

        // Asynchronous reset mid-WORK
        applyStimulus(1, 0, 0, 0);
        idle(10);
        #3 rst = 1'b1;
        #1;
        modelReset();
        checkOutput("asyncRstPhase", phase_o, 8'd0);
        checkOutput("asyncRstMin", min_bcd_o, 8'h02);
        checkOutput("asyncRstSess", session_bcd_o, 8'h00);
        checkOutput("asyncRstRun", run_o, 8'd0);
        idle(2);
        releaseReset();

        // Random pulse traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 4,
                          $urandom_range(0, 99) < 3,  $urandom_range(0, 99) < 1);
        end

        // Session counter wrap 99 -> 00
        rst = 1'b1;
        #1;
        modelReset();
        idle(2);
        releaseReset();
        applyStimulus(1, 0, 0, 0);
        for (int n = 1; n <= 100; n++) begin
            idle(480);
            if (n == 99) checkOutput("sess99", session_bcd_o, 8'h99);
            if (n == 100) checkOutput("sessWrap", session_bcd_o, 8'h00);
            applyStimulus(0, 0, 1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
